wb_mtimer: RTL
==============

# wb_mtimer

Wishbone-slave machine timer that drives the `timerInterrupt` input of the VexRiscv core, which is currently tied low. It maintains a 64-bit free-running `mtime` counter, advanced by a programmable prescaler, and a 64-bit `mtimecmp` register, both exposed through registers. It raises a level interrupt while `mtime >= mtimecmp`. It sits on a spare crossbar slave port, with its decode region selected by the upper address nibble, alongside the boot ROM, SRAM, LED PWM, QSPI flash and USB serial slaves.

## Interface

**Parameters**
- `AW`, default 30: Wishbone word-address width.
- `DW`, default 32: Wishbone data width. Only 32 is supported.
- `PRESCALE`, default 48: clock cycles per `mtime` increment. The default gives 1 µs at 48 MHz. The legal range is 1..65535.

**Ports**
- `wb_clk_i`, input, 1: the single clock.
- `wb_reset_i`, input, 1: reset, asynchronous and active-low.
- `wb_adr_i`, input, AW: word address. Only `[2:0]` is decoded.
- `wb_dat_i`, input, DW: write data.
- `wb_dat_o`, output, DW: read data, registered.
- `wb_we_i`, input, 1: write enable.
- `wb_sel_i`, input, DW/8: byte-lane enables for writes.
- `wb_ack_o`, output, 1: single-cycle acknowledge.
- `wb_cyc_i`, input, 1: bus cycle.
- `wb_stb_i`, input, 1: strobe.
- `timer_irq`, output, 1: registered interrupt level to the CPU.

## Operation

**Register map** (word offsets in `adr[2:0]`)
- 0 `MTIME_LO`: R/W.
- 1 `MTIME_HI`: R/W. Reads return the shadow value, not the live upper word.
- 2 `MTIMECMP_LO`: R/W.
- 3 `MTIMECMP_HI`: R/W.
- 4 `CTRL`: bit0 `EN` (counting enable), bit1 `IE` (interrupt enable). Other bits read 0.
- 5 `STATUS`: read-only. bit0 `MATCH` is the live value of `mtime >= mtimecmp`.
- 6 and 7: read 0. Writes are ignored but still acked.

**Reset values**
- `mtime` = 0.
- `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
- `CTRL` = 2'b01 (counting on, interrupt off).
- Shadow = 0, prescaler = 0.
- `wb_ack_o` = 0, `wb_dat_o` = 0, `timer_irq` = 0.

**Prescaler**
- The prescaler counts 0..PRESCALE-1 while `EN`=1. When it is at PRESCALE-1 it wraps to 0 and asserts `tick` for one cycle.
- With PRESCALE=1, `tick` is asserted every cycle.
- When `EN`=0 the prescaler holds its value and `mtime` holds.

**Counter**
- On `tick`, `mtime` ← `mtime` + 1 as a 64-bit value. 2^64-1 wraps to 0.

**Atomic read**
- Reading `MTIME_LO` returns the live low word and, in the same edge, copies the live upper word into the shadow.
- Software reads LO then HI. The HI read returns the shadow, so a carry between the two reads never yields a torn value.

**Writes**
- Writes apply per byte lane under `wb_sel_i`.
- A write to `MTIME_LO` or `MTIME_HI` replaces the addressed word and suppresses any `tick` increment in that cycle.
- The prescaler is not reset by an `mtime` write.
- A write to the other `mtime` word leaves that word unchanged.

**Interrupt**
- `timer_irq` ← `IE` & (`mtime` >= `mtimecmp`), registered, using an unsigned 64-bit compare.
- The interrupt is a level. It is cleared only by raising `mtimecmp`, lowering `mtime`, or clearing `IE`.

## Timing

**Handshake**
- A request is accepted at the rising edge where `wb_cyc_i & wb_stb_i & !wb_ack_o`.
- `wb_ack_o` is high for exactly the following cycle, so latency is 1. Read data is valid on `wb_dat_o` in that same cycle.
- Back-to-back strobes are acked every other cycle.
- A request is never acked while `wb_cyc_i` is low.
- If `wb_cyc_i` drops while `wb_ack_o` is high, the access already took effect.

**Write commit**
- The register updates at the accepting edge, so the new value is visible to a read accepted at the next acceptance.

**Interrupt latency**
- `timer_irq` reflects the compare state one cycle after the edge on which `mtime`, `mtimecmp` or `IE` changed.

**Reset**
- Asserting reset at any point, including mid-access, forces all reset values immediately (asynchronously). `wb_ack_o` drops without completing the access.
- Deassertion is synchronised by the system reset logic. The first request can be accepted on the first edge after release.

## Test plan

- **Reset values:** after reset, read offsets 0..5 → 0, 0, FFFFFFFF, FFFFFFFF, 0x1, 0. `timer_irq`=0. Each access gets exactly one ack, one cycle after acceptance.
- **Prescale and count:** with PRESCALE=4, EN=1, wait 40 cycles → `MTIME_LO` reads 10 (±1 for bus latency). Write `CTRL`=0, wait 40 cycles → value unchanged.
- **Compare interrupt:**
  - Write `MTIMECMP`=20 (HI first, then LO) and `IE`=1 → `timer_irq` rises one cycle after `mtime` reaches 20, and `STATUS`=1.
  - Write `MTIMECMP_LO`=1000 → `timer_irq` falls one cycle later.
- **Carry-safe read:** write `MTIME_HI`=0, `MTIME_LO`=FFFFFFFF, then read LO then HI across the carry → the pair reads FFFFFFFF/0, never FFFFFFFF/1. A following LO/HI pair reads a small value/1.
- **Write vs tick collision:** with PRESCALE=1, write `MTIME_LO`=0x55 → the next read of `MTIME_LO` (3 cycles later) returns 0x57, with no extra increment on the write edge. A byte write with sel=4'b0001 and data 0xAA changes only bits [7:0].
- **Reset mid-operation:** with `mtime` nonzero and `timer_irq`=1, assert reset during an accepted read → `wb_ack_o`, `timer_irq` and `mtime` go to 0 immediately, and `mtimecmp` reads all-ones after release.

Source files
------------

// File: rtl/wb_mtimer.sv
// Wishbone machine timer.
// Keeps a 64-bit mtime counter advanced once every PRESCALE clocks while enabled, and a
// 64-bit mtimecmp register. Raises a registered level interrupt while IE is set and
// mtime >= mtimecmp (unsigned).
//
// Ports:
//   wb_clk_i    single clock
//   wb_reset_i  asynchronous active-low reset
//   wb_adr_i    word address, only [2:0] decoded
//   wb_dat_i    write data, applied per byte lane under wb_sel_i
//   wb_dat_o    registered read data, valid while wb_ack_o is high
//   wb_we_i     write enable
//   wb_sel_i    byte-lane enables
//   wb_ack_o    single-cycle acknowledge, one cycle after acceptance
//   wb_cyc_i    bus cycle
//   wb_stb_i    strobe
//   timer_irq   registered interrupt level
//
// Word map: 0 MTIME_LO, 1 MTIME_HI (shadow on read), 2 MTIMECMP_LO, 3 MTIMECMP_HI,
//           4 CTRL {IE, EN}, 5 STATUS {MATCH}, 6..7 read 0.
module wb_mtimer #(
  parameter int unsigned AW       = 30,
  parameter int unsigned DW       = 32,
  parameter int unsigned PRESCALE = 48
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic            wb_we_i,
  input  logic [DW/8-1:0] wb_sel_i,
  output logic            wb_ack_o,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic            timer_irq
);

  localparam int unsigned PW = 16;
  localparam logic [PW-1:0] PreLast = PW'(PRESCALE - 1);

  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   cmp_q, cmp_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          ack_q;
  logic [DW-1:0] dat_q;
  logic          irq_q;

  logic          acc;
  logic          tick;
  logic          match;
  logic [DW-1:0] rd_data;

  // Upper address bits belong to the crossbar decode, not to this slave.
  logic unused_adr;
  assign unused_adr = ^wb_adr_i[AW-1:3];

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign acc   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign match = (mtime_q >= cmp_q);

  always_comb begin
    rd_data = '0;
    case (wb_adr_i[2:0])
      3'd0:    rd_data = mtime_q[31:0];
      3'd1:    rd_data = shadow_q;
      3'd2:    rd_data = cmp_q[31:0];
      3'd3:    rd_data = cmp_q[63:32];
      3'd4:    rd_data = {{(DW-2){1'b0}}, ctrl_q};
      3'd5:    rd_data = {{(DW-1){1'b0}}, match};
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    ctrl_d   = ctrl_q;
    shadow_d = shadow_q;
    pre_d    = pre_q;
    tick     = 1'b0;

    if (ctrl_q[0]) begin
      if (pre_q == PreLast) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    if (tick) mtime_d = mtime_q + 64'd1;

    if (acc && wb_we_i) begin
      // mtime writes build from mtime_q, so a coincident tick is dropped.
      case (wb_adr_i[2:0])
        3'd0: mtime_d = {mtime_q[63:32], merge_word(mtime_q[31:0], wb_dat_i, wb_sel_i)};
        3'd1: mtime_d = {merge_word(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
        3'd2: cmp_d   = {cmp_q[63:32], merge_word(cmp_q[31:0], wb_dat_i, wb_sel_i)};
        3'd3: cmp_d   = {merge_word(cmp_q[63:32], wb_dat_i, wb_sel_i), cmp_q[31:0]};
        3'd4: if (wb_sel_i[0]) ctrl_d = wb_dat_i[1:0];
        default: ;
      endcase
    end

    // Latch the upper word with the low-word read so the LO/HI pair is coherent.
    if (acc && !wb_we_i && (wb_adr_i[2:0] == 3'd0)) shadow_d = mtime_q[63:32];
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
    if (!wb_reset_i) begin
      mtime_q  <= '0;
      cmp_q    <= '1;
      ctrl_q   <= 2'b01;
      shadow_q <= '0;
      pre_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      ctrl_q   <= ctrl_d;
      shadow_q <= shadow_d;
      pre_q    <= pre_d;
      ack_q    <= acc;
      if (acc && !wb_we_i) dat_q <= rd_data;
      irq_q    <= ctrl_q[1] & match;
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign timer_irq = irq_q;

endmodule
